// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: opcode/ALU-control constants and the decoded control struct
package alu_issue_stage_pkg;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_LUI  = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_LW   = 3'd6;
    localparam logic [2:0] OP_SW   = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_SLT  = 2'd2;
    localparam logic [1:0] ALU_SHL4 = 2'd3;

    typedef struct packed {
        logic [1:0] alu_ctl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } ctrl_t;
endpackage

// File: rtl/alu_issue_stage_decode.sv
// issue_decode: combinational opcode decoder producing ALU control, operand B and sideband bits
//   op      in  opcode
//   rt_val  in  register value used as operand B for register-register ops
//   imm     in  immediate field
//   ctrl    out decoded ALU control + sideband
//   b       out selected operand B
module issue_decode
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [IMM_W-1:0] imm,
    output ctrl_t            ctrl,
    output logic [WIDTH-1:0] b
);
    logic [WIDTH-1:0] sx;
    logic [WIDTH-1:0] zx;
    logic             rr;

    assign sx = WIDTH'($signed(imm));
    assign zx = WIDTH'(imm);
    assign rr = op == OP_ADD || op == OP_SUB || op == OP_SLT || op == OP_BEQ;

    assign ctrl.alu_ctl   = (op == OP_SUB || op == OP_BEQ) ? ALU_SUB :
                            op == OP_SLT ? ALU_SLT :
                            op == OP_LUI ? ALU_SHL4 : ALU_ADD;
    assign ctrl.reg_write = !(op == OP_BEQ || op == OP_SW);
    assign ctrl.mem_read  = op == OP_LW;
    assign ctrl.mem_write = op == OP_SW;
    assign ctrl.branch    = op == OP_BEQ;
    assign b              = rr ? rt_val : op == OP_LUI ? zx : sx;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand/control issue stage with a 2-entry skid buffer in front of the ALU
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous squash of both buffered entries
//   in_valid/in_ready     upstream handshake; in_ready is !skid_valid
//   in_op..in_rd          decoded instruction fields
//   out_valid/out_ready   downstream handshake
//   alu_ctl..branch       registered operand bundle; sideband bits masked by out_valid
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4,
    parameter int RA_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_rs_val,
    input  logic [WIDTH-1:0] in_rt_val,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [RA_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] store_data,
    output logic [RA_W-1:0]  out_rd,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch
);
    typedef struct packed {
        ctrl_t            ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sd;
        logic [RA_W-1:0]  rd;
    } bundle_t;

    bundle_t main_q, skid_q, in_b;
    logic    main_valid, skid_valid, accept;

    issue_decode #(.WIDTH(WIDTH), .IMM_W(IMM_W)) u_dec (
        .op     (in_op),
        .rt_val (in_rt_val),
        .imm    (in_imm),
        .ctrl   (in_b.ctrl),
        .b      (in_b.b)
    );

    assign in_b.a  = in_rs_val;
    assign in_b.sd = in_rt_val;
    assign in_b.rd = in_rd;
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;

    // skid_valid implies main_valid, so a full skid drains whenever out_ready is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || out_ready) begin
                main_q     <= in_b;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= in_b;
                skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            main_valid <= 1'b0;
        end
    end

    assign out_valid  = main_valid;
    assign alu_ctl    = main_q.ctrl.alu_ctl;
    assign alu_a      = main_q.a;
    assign alu_b      = main_q.b;
    assign store_data = main_q.sd;
    assign out_rd     = main_q.rd;
    assign reg_write  = main_valid && main_q.ctrl.reg_write;
    assign mem_read   = main_valid && main_q.ctrl.mem_read;
    assign mem_write  = main_valid && main_q.ctrl.mem_write;
    assign branch     = main_valid && main_q.ctrl.branch;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [7:0] in_rs_val = '0;
    logic [7:0] in_rt_val = '0;
    logic [3:0] in_imm = '0;
    logic [1:0] in_rd = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] alu_ctl;
    logic [7:0] alu_a, alu_b, store_data;
    logic [1:0] out_rd;
    logic       reg_write, mem_read, mem_write, branch;
    logic [31:0] obs;
    int vectors = 0;
    int miscompares = 0;

    alu_issue_stage #(.WIDTH(8), .IMM_W(4), .RA_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_imm(in_imm), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .store_data(store_data), .out_rd(out_rd),
        .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch)
    );

    always #5 clk = ~clk;

    assign obs = {alu_ctl, alu_a, alu_b, store_data, out_rd, reg_write, mem_read, mem_write, branch};

    function automatic logic [31:0] pk(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] sd, input logic [1:0] rd,
                                       input logic rw, input logic mr, input logic mw, input logic br);
        return {c, a, b, sd, rd, rw, mr, mw, br};
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [7:0] rs, input logic [7:0] rt,
                                          input logic [3:0] imm, input logic [1:0] rd);
        logic [7:0] sx;
        sx = {{4{imm[3]}}, imm};
        case (op)
            3'd0: return pk(2'd0, rs, rt, rt, rd, 1, 0, 0, 0);
            3'd1: return pk(2'd1, rs, rt, rt, rd, 1, 0, 0, 0);
            3'd2: return pk(2'd2, rs, rt, rt, rd, 1, 0, 0, 0);
            3'd3: return pk(2'd0, rs, sx, rt, rd, 1, 0, 0, 0);
            3'd4: return pk(2'd3, rs, {4'h0, imm}, rt, rd, 1, 0, 0, 0);
            3'd5: return pk(2'd1, rs, rt, rt, rd, 0, 0, 0, 1);
            3'd6: return pk(2'd0, rs, sx, rt, rd, 1, 1, 0, 0);
            default: return pk(2'd0, rs, sx, rt, rd, 0, 0, 1, 0);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] rs, input logic [7:0] rt,
                         input logic [3:0] imm, input logic [1:0] rd);
        in_valid = v; in_op = op; in_rs_val = rs; in_rt_val = rt; in_imm = imm; in_rd = rd;
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: valid=%b ready=%b bundle=%h expected valid=0 ready=1 bundle=00000000", out_valid, in_ready, obs);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        drive(1, 3'd3, 8'h05, 8'h00, 4'hF, 2'd2);
        tick;
        drive(0, 3'd0, 8'h00, 8'h00, 4'h0, 2'd0);
        vectors++;
        if (out_valid !== 1'b1 || obs !== pk(0, 8'h05, 8'hFF, 8'h00, 2, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL addi: valid=%b bundle=%h expected valid=1 bundle=%h", out_valid, obs, pk(0, 8'h05, 8'hFF, 8'h00, 2, 1, 0, 0, 0));
        end
        tick;
        vectors++;
        if (out_valid !== 1'b0 || reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL addi_drain: valid=%b reg_write=%b expected 0 0", out_valid, reg_write);
        end
    endtask

    task automatic test_lui_sw;
        out_ready = 1'b1;
        drive(1, 3'd4, 8'h00, 8'h00, 4'hA, 2'd1);
        tick;
        drive(1, 3'd7, 8'h10, 8'h3C, 4'h2, 2'd0);
        vectors++;
        if (out_valid !== 1'b1 || obs !== pk(3, 8'h00, 8'h0A, 8'h00, 1, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL lui: valid=%b bundle=%h expected valid=1 bundle=%h", out_valid, obs, pk(3, 8'h00, 8'h0A, 8'h00, 1, 1, 0, 0, 0));
        end
        tick;
        drive(0, 3'd0, 8'h00, 8'h00, 4'h0, 2'd0);
        vectors++;
        if (out_valid !== 1'b1 || obs !== pk(0, 8'h10, 8'h02, 8'h3C, 0, 0, 0, 1, 0)) begin
            miscompares++;
            $display("FAIL sw: valid=%b bundle=%h expected valid=1 bundle=%h", out_valid, obs, pk(0, 8'h10, 8'h02, 8'h3C, 0, 0, 0, 1, 0));
        end
        tick;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(1, 3'd1, 8'h21, 8'h03, 4'h0, 2'd1);
        tick;
        out_ready = 1'b0;
        drive(1, 3'd2, 8'h80, 8'h01, 4'h0, 2'd2);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== pk(1, 8'h21, 8'h03, 8'h03, 1, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL b2b_sub: valid=%b ready=%b bundle=%h expected 1 1 %h", out_valid, in_ready, obs, pk(1, 8'h21, 8'h03, 8'h03, 1, 1, 0, 0, 0));
        end
        tick;
        drive(1, 3'd5, 8'h44, 8'h44, 4'h5, 2'd3);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== pk(1, 8'h21, 8'h03, 8'h03, 1, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL b2b_full: valid=%b ready=%b bundle=%h expected 1 0 %h", out_valid, in_ready, obs, pk(1, 8'h21, 8'h03, 8'h03, 1, 1, 0, 0, 0));
        end
        tick;
        vectors++;
        if (in_ready !== 1'b0 || obs !== pk(1, 8'h21, 8'h03, 8'h03, 1, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL b2b_hold: ready=%b bundle=%h expected 0 %h", in_ready, obs, pk(1, 8'h21, 8'h03, 8'h03, 1, 1, 0, 0, 0));
        end
        out_ready = 1'b1;
        tick;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== pk(2, 8'h80, 8'h01, 8'h01, 2, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL b2b_slt: valid=%b ready=%b bundle=%h expected 1 1 %h", out_valid, in_ready, obs, pk(2, 8'h80, 8'h01, 8'h01, 2, 1, 0, 0, 0));
        end
        tick;
        drive(0, 3'd0, 8'h00, 8'h00, 4'h0, 2'd0);
        vectors++;
        if (out_valid !== 1'b1 || obs !== pk(1, 8'h44, 8'h44, 8'h44, 3, 0, 0, 0, 1)) begin
            miscompares++;
            $display("FAIL b2b_beq: valid=%b bundle=%h expected 1 %h", out_valid, obs, pk(1, 8'h44, 8'h44, 8'h44, 3, 0, 0, 0, 1));
        end
        tick;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1, 3'd0, 8'h11, 8'h01, 4'h0, 2'd1);
        tick;
        drive(1, 3'd0, 8'h22, 8'h02, 4'h0, 2'd2);
        tick;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_fill: ready=%b valid=%b expected 0 1", in_ready, out_valid);
        end
        flush = 1'b1;
        drive(1, 3'd0, 8'h33, 8'h03, 4'h0, 2'd3);
        tick;
        flush = 1'b0;
        drive(0, 3'd0, 8'h00, 8'h00, 4'h0, 2'd0);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_full: valid=%b ready=%b reg_write=%b expected 0 1 0", out_valid, in_ready, reg_write);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_ghost%0d: valid=%b expected 0", i, out_valid);
            end
        end
        out_ready = 1'b0;
        drive(1, 3'd0, 8'h44, 8'h04, 4'h0, 2'd0);
        tick;
        flush = 1'b1;
        drive(1, 3'd0, 8'h55, 8'h05, 4'h0, 2'd1);
        tick;
        flush = 1'b0;
        drive(0, 3'd0, 8'h00, 8'h00, 4'h0, 2'd0);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_accept: valid=%b ready=%b expected 0 1", out_valid, in_ready);
        end
        tick;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_accept_late: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(1, 3'd0, 8'h66, 8'h07, 4'h0, 2'd1);
        tick;
        drive(1, 3'd6, 8'h77, 8'h08, 4'h3, 2'd2);
        tick;
        drive(0, 3'd0, 8'h00, 8'h00, 4'h0, 2'd0);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_fill: ready=%b valid=%b expected 0 1", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 32'h0) begin
            miscompares++;
            $display("FAIL arst: valid=%b ready=%b bundle=%h expected 0 1 00000000", out_valid, in_ready, obs);
        end
        #2 rst_n = 1'b1;
        tick;
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [31:0] exp;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while ((sent < 1000 || got < 1000) && cyc < 20000) begin
            drive(sent < 1000 && $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                  8'($urandom), 4'($urandom), 2'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            if (out_valid && out_ready) begin
                vectors++;
                got++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra: bundle=%h expected no output", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        miscompares++;
                        $display("FAIL rand_data #%0d: bundle=%h expected %h", got, obs, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_op, in_rs_val, in_rt_val, in_imm, in_rd));
                sent++;
            end
            tick;
            cyc++;
        end
        drive(0, 3'd0, 8'h00, 8'h00, 4'h0, 2'd0);
        vectors++;
        if (got != 1000 || q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_count: received=%0d pending=%0d expected 1000 0", got, q.size());
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_lui_sw;
        test_back_to_back;
        test_flush;
        test_async_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue/operand stage directly upstream of the 8-bit ALU. Takes one decoded instruction per handshake: opcode, two register-file read values, immediate and destination register.
- Selects operand B as a register value, sign-extended immediate or zero-extended immediate, and generates the 2-bit ALU control.
- Registers the result through a 2-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush used on branch redirect.

Parameters:
- WIDTH, 8, datapath width of operands A/B
- IMM_W, 4, immediate field width; must be <= WIDTH
- RA_W, 2, register address width for the destination register

Ports:
- clk  input  1  clock; all state on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous squash of all buffered entries
- in_valid  input  1  upstream offers an instruction
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_op  input  3  opcode: 0 ADD, 1 SUB, 2 SLT, 3 ADDI, 4 LUI, 5 BEQ, 6 LW, 7 SW
- in_rs_val  input  WIDTH  register value for operand A
- in_rt_val  input  WIDTH  register value for operand B / store data
- in_imm  input  IMM_W  immediate field
- in_rd  input  RA_W  destination register
- out_valid  output  1  ALU operand bundle valid
- out_ready  input  1  downstream consumes the bundle
- alu_ctl  output  2  0 add, 1 sub, 2 signed less-than, 3 B<<4
- alu_a  output  WIDTH  operand A
- alu_b  output  WIDTH  operand B
- store_data  output  WIDTH  in_rt_val, passed through for SW
- out_rd  output  RA_W  destination register
- reg_write, mem_read, mem_write, branch  output  1 each  sideband controls

Behaviour:
- Decode, combinational before the register:
  - ADD, SUB, SLT: alu_ctl 0/1/2; B = rt_val; reg_write=1.
  - ADDI: alu_ctl 0; B = sign-extended imm; reg_write=1.
  - LUI: alu_ctl 3; B = zero-extended imm; reg_write=1.
  - BEQ: alu_ctl 1; A = rs_val; B = rt_val; branch=1; reg_write=0.
  - LW: alu_ctl 0; B = sign-extended imm; mem_read=1; reg_write=1.
  - SW: alu_ctl 0; B = sign-extended imm; mem_write=1; reg_write=0.
  - A = rs_val for all opcodes.
- Storage: a main (output) register and a skid register, each a full decoded bundle plus a valid bit.
- Accept condition: in_valid && in_ready.
  - Main empty, or out_ready high: bundle goes to main.
  - Otherwise: bundle goes to skid.
- Drain: out_valid && out_ready && skid_valid moves skid to main and clears skid. No accept is possible that cycle (in_ready=0).
- Bundle contents are not sampled while the handshake is inactive.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 per cycle while out_ready stays high.
- Outputs are held stable while out_valid && !out_ready.
- in_ready is registered: in_ready = !skid_valid at all times.
- Flush has priority over everything, including a simultaneous accept or drain. Next cycle main_valid=0, skid_valid=0, in_ready=1; any accepted instruction is discarded. Data registers may hold stale values; sideband bits are masked by valid.
- Reset (asynchronous, any time, including mid-stall):
  - main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1.
  - All data outputs 0: alu_ctl, alu_a, alu_b, store_data, out_rd, reg_write, mem_read, mem_write, branch.
- Width rules: sign extension replicates in_imm[IMM_W-1]; zero extension pads with 0. No arithmetic is done in this stage.
- Full condition: skid_valid=1 deasserts in_ready. There is no overflow path.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_SW), ALU control constants (ALU_ADD=0, ALU_SUB=1, ALU_SLT=2, ALU_SHL4=3), and the decoded-bundle struct/width definition.
- Sub-module: issue_decode, purely combinational opcode-to-bundle decoder (ctl, B select, sideband).
- Top level: skid buffer and handshake.

Test Plan:
- Reset then single ADDI (rs_val=0x05, imm=0xF, rd=2), out_ready=1 -> next cycle out_valid=1, alu_ctl=0, alu_a=0x05, alu_b=0xFF, reg_write=1, out_rd=2; the cycle after, out_valid=0.
- LUI imm=0xA, then SW rs_val=0x10, rt_val=0x3C, imm=0x2 -> alu_ctl=3, alu_b=0x0A; then alu_ctl=0, alu_b=0x02, store_data=0x3C, mem_write=1, reg_write=0.
- Back-to-back SUB, SLT, BEQ with out_ready=0 after the first accept -> SUB held stable in main, SLT in skid, in_ready=0, BEQ not accepted. Raise out_ready -> SUB, SLT, BEQ delivered in order with alu_ctl 1, 2, 1; BEQ has branch=1.
- Flush asserted in the same cycle as in_valid while both entries are full -> next cycle out_valid=0, in_ready=1; no flushed bundle ever appears.
- rst_n pulled low asynchronously mid-cycle with skid full -> out_valid, in_ready=1 and all outputs 0 immediately, without waiting for a clock edge.
- Random valid/ready streams of 1000 instructions -> output order and contents match a reference queue; no drops or duplicates.
